// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, requester IDs and counter width for mem_arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;
   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;
   localparam int   CNT_W = 3;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the arbiter
//   slave  : arbiter view (requests and mem_rdata in, handshakes and memory strobes out)
//   master : requester/memory view (the opposite directions)
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic              d_done;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ready, i_rvalid, i_rdata, d_ready, d_done, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ready, i_rvalid, i_rdata, d_ready, d_done, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker with a one-bit last-winner pointer
//   clk, reset       : clock, async active-high reset (last resets to REQ_I)
//   i_req_i, i_req_d : fetch / data requests
//   i_upd            : record the current winner as last
//   o_gnt            : one-hot grant, bit REQ_I = fetch, bit REQ_D = data
//   o_last           : last winner
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_req_i,
   input  logic       i_req_d,
   input  logic       i_upd,
   output logic [1:0] o_gnt,
   output logic       o_last
);
   logic r_last;
   logic w_gnt_d;
   // on a tie the requester that did not win last time gets the grant
   assign w_gnt_d = i_req_d & (~i_req_i | (r_last == REQ_I));
   assign o_gnt   = {w_gnt_d, i_req_i & ~w_gnt_d};
   assign o_last  = r_last;
   always_ff @(posedge clk or posedge reset)
      if (reset)
         r_last <= REQ_I;
      else if (i_upd && |o_gnt)
         r_last <= w_gnt_d ? REQ_D : REQ_I;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between fetch and data requesters
//   clk, reset : clock, async active-high reset
//   bus        : mem_arbiter_if.slave carrying fetch, data and memory signals
//   MEM_LAT    : cycles from mem_en to valid mem_rdata (1..7)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input logic           clk,
   input logic           reset,
   mem_arbiter_if.slave  bus
);
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_mem_en;
   logic              r_mem_we;
   logic              r_i_rvalid;
   logic              r_d_done;
   logic [1:0]        w_gnt;
   logic              w_owner;
   logic              w_idle;
   logic              w_accept;
   logic              w_fire;
   assign w_idle   = r_state == ST_IDLE;
   assign w_accept = w_idle & (bus.i_req | bus.d_req);
   // the round-robin pointer is updated on every acceptance, so it doubles as the owner
   rr_arb2 u_rr (
      .clk     (clk),
      .reset   (reset),
      .i_req_i (bus.i_req),
      .i_req_d (bus.d_req),
      .i_upd   (w_accept),
      .o_gnt   (w_gnt),
      .o_last  (w_owner)
   );
   // completion pulse is registered, so it is raised one cycle before the counter reaches 0
   assign w_fire = ((r_state == ST_ISSUE) && (MEM_LAT == 1)) ||
                   ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_i_rvalid <= 1'b0;
         r_d_done   <= 1'b0;
      end else begin
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_i_rvalid <= w_fire & (w_owner == REQ_I);
         r_d_done   <= w_fire & (w_owner == REQ_D);
         case (r_state)
            ST_IDLE:
               if (w_accept) begin
                  r_addr   <= w_gnt[REQ_D] ? bus.d_addr : bus.i_addr;
                  r_wdata  <= w_gnt[REQ_D] ? bus.d_wdata : '0;
                  r_mem_en <= 1'b1;
                  r_mem_we <= w_gnt[REQ_D] & bus.d_we;
                  r_state  <= ST_ISSUE;
               end
            ST_ISSUE: begin
               r_cnt   <= CNT_W'(MEM_LAT - 1);
               r_state <= ST_WAIT;
            end
            ST_WAIT:
               if (r_cnt == '0)
                  r_state <= ST_IDLE;
               else
                  r_cnt <= r_cnt - 1'b1;
            default: r_state <= ST_IDLE;
         endcase
      end
   assign bus.i_ready   = w_idle & w_gnt[REQ_I];
   assign bus.d_ready   = w_idle & w_gnt[REQ_D];
   assign bus.i_rvalid  = r_i_rvalid;
   assign bus.d_done    = r_d_done;
   assign bus.i_rdata   = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with MEM_LAT = 1 and MEM_LAT = 2
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] mem1 [256];
   logic [31:0] mem2 [256];
   logic [31:0] m1_rd, m2_rd_a, m2_rd_b;
   always #5 clk = ~clk;
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
   // memories preload word k with 0xA5000000 | k while reset is high
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 256; k++) mem1[k] <= 32'hA500_0000 | 32'(k);
         m1_rd <= '0;
      end else if (b1.mem_en) begin
         if (b1.mem_we) mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
         m1_rd <= mem1[b1.mem_addr[9:2]];
      end
   end
   always @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 256; k++) mem2[k] <= 32'hA500_0000 | 32'(k);
         m2_rd_a <= '0;
         m2_rd_b <= '0;
      end else begin
         if (b2.mem_en) begin
            if (b2.mem_we) mem2[b2.mem_addr[9:2]] <= b2.mem_wdata;
            m2_rd_a <= mem2[b2.mem_addr[9:2]];
         end
         m2_rd_b <= m2_rd_a;
      end
   end
   assign b1.mem_rdata = m1_rd;
   assign b2.mem_rdata = m2_rd_b;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   initial begin
      b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
      b2.i_req = 0; b2.i_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
      nxt(); nxt();
      chk("rst_mem_en", b1.mem_en, 0);
      chk("rst_i_rvalid", b1.i_rvalid, 0);
      chk("rst_d_done", b2.d_done, 0);
      chk("rst_mem_addr", b2.mem_addr, 0);
      chk("rst_i_ready", b1.i_ready, 0);
      reset = 0;
      // fetch read, MEM_LAT = 1
      nxt(); b1.i_req = 1; b1.i_addr = 32'h40; #1;
      chk("f_i_ready", b1.i_ready, 1);
      chk("f_d_ready", b1.d_ready, 0);
      nxt(); b1.i_req = 0; #1;
      chk("f_mem_en", b1.mem_en, 1);
      chk("f_mem_addr", b1.mem_addr, 32'h40);
      chk("f_mem_we", b1.mem_we, 0);
      chk("f_rvalid_early", b1.i_rvalid, 0);
      nxt(); #1;
      chk("f_rvalid", b1.i_rvalid, 1);
      chk("f_rdata", b1.i_rdata, 32'hA500_0010);
      chk("f_mem_en_off", b1.mem_en, 0);
      nxt(); #1;
      chk("f_rvalid_once", b1.i_rvalid, 0);
      // data write then read, MEM_LAT = 2
      nxt(); b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h100; b2.d_wdata = 32'hDEAD_BEEF; #1;
      chk("w_d_ready", b2.d_ready, 1);
      nxt(); b2.d_req = 0; #1;
      chk("w_mem_en", b2.mem_en, 1);
      chk("w_mem_we", b2.mem_we, 1);
      chk("w_mem_addr", b2.mem_addr, 32'h100);
      chk("w_mem_wdata", b2.mem_wdata, 32'hDEAD_BEEF);
      nxt(); #1;
      chk("w_done_early", b2.d_done, 0);
      nxt(); #1;
      chk("w_done", b2.d_done, 1);
      nxt(); b2.d_req = 1; b2.d_we = 0; #1;
      chk("r_d_ready", b2.d_ready, 1);
      nxt(); b2.d_req = 0; #1;
      chk("r_mem_en", b2.mem_en, 1);
      chk("r_mem_we", b2.mem_we, 0);
      nxt(); #1;
      chk("r_done_early", b2.d_done, 0);
      nxt(); #1;
      chk("r_done", b2.d_done, 1);
      chk("r_rdata", b2.d_rdata, 32'hDEAD_BEEF);
      // data request arriving while a fetch is in flight, MEM_LAT = 1
      nxt(); b1.i_req = 1; b1.i_addr = 32'h44; #1;
      chk("b_i_ready", b1.i_ready, 1);
      nxt(); b1.i_req = 0; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h80; #1;
      chk("b_d_ready_c1", b1.d_ready, 0);
      chk("b_mem_en_c1", b1.mem_en, 1);
      nxt(); #1;
      chk("b_d_ready_c2", b1.d_ready, 0);
      chk("b_mem_en_c2", b1.mem_en, 0);
      chk("b_rvalid_c2", b1.i_rvalid, 1);
      nxt(); #1;
      chk("b_d_ready_c3", b1.d_ready, 1);
      chk("b_mem_en_c3", b1.mem_en, 0);
      nxt(); b1.d_req = 0; #1;
      chk("b_mem_en_c4", b1.mem_en, 1);
      chk("b_mem_addr_c4", b1.mem_addr, 32'h80);
      nxt(); #1;
      chk("b_d_done", b1.d_done, 1);
      chk("b_d_rdata", b1.d_rdata, 32'hA500_0020);
      // data request withdrawn before acceptance
      nxt(); b1.i_req = 1; b1.i_addr = 32'h48; #1;
      chk("x_i_ready", b1.i_ready, 1);
      nxt(); b1.i_req = 0; b1.d_req = 1; #1;
      chk("x_d_ready_c1", b1.d_ready, 0);
      nxt(); b1.d_req = 0; #1;
      chk("x_d_ready_c2", b1.d_ready, 0);
      nxt(); #1;
      chk("x_d_ready_c3", b1.d_ready, 0);
      chk("x_mem_en_c3", b1.mem_en, 0);
      nxt(); #1;
      chk("x_mem_en_c4", b1.mem_en, 0);
      // reset during ISSUE drops mem_en at once and suppresses the pulse
      nxt(); b1.i_req = 1; b1.i_addr = 32'h4C; #1;
      chk("ri_i_ready", b1.i_ready, 1);
      nxt(); b1.i_req = 0; #1;
      chk("ri_mem_en", b1.mem_en, 1);
      reset = 1; #1;
      chk("ri_mem_en_async", b1.mem_en, 0);
      nxt(); #1;
      chk("ri_no_rvalid", b1.i_rvalid, 0);
      reset = 0;
      // tie after reset: D first, then strict alternation
      b1.i_req = 1; b1.i_addr = 32'h40; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h80;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk($sformatf("t%0d_d_ready", g), b1.d_ready, (g % 2 == 0));
         chk($sformatf("t%0d_i_ready", g), b1.i_ready, (g % 2 == 1));
         nxt(); #1;
         chk($sformatf("t%0d_busy_ready", g), {b1.i_ready, b1.d_ready}, 0);
         nxt(); #1;
         chk($sformatf("t%0d_d_done", g), b1.d_done, (g % 2 == 0));
         chk($sformatf("t%0d_i_rvalid", g), b1.i_rvalid, (g % 2 == 1));
         nxt();
      end
      b1.i_req = 0; b1.d_req = 0;
      // reset while waiting with the counter non-zero, MEM_LAT = 2
      b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h100; #1;
      chk("rw_d_ready", b2.d_ready, 1);
      nxt(); b2.d_req = 0; #1;
      chk("rw_mem_en", b2.mem_en, 1);
      nxt(); reset = 1; #1;
      chk("rw_done_c2", b2.d_done, 0);
      chk("rw_mem_en_c2", b2.mem_en, 0);
      nxt(); #1;
      chk("rw_no_done", b2.d_done, 0);
      reset = 0;
      b2.i_req = 1; b2.i_addr = 32'h40; b2.d_req = 1; b2.d_addr = 32'h100; #1;
      chk("rw_tie_d_ready", b2.d_ready, 1);
      chk("rw_tie_i_ready", b2.i_ready, 0);
      nxt(); b2.d_req = 0; #1;
      chk("rw_post_mem_en", b2.mem_en, 1);
      chk("rw_post_addr", b2.mem_addr, 32'h100);
      chk("rw_post_i_wait", b2.i_ready, 0);
      nxt(); nxt(); #1;
      chk("rw_post_done", b2.d_done, 1);
      chk("rw_post_rdata", b2.d_rdata, 32'hA500_0040);
      nxt(); #1;
      chk("rw_post_i_ready", b2.i_ready, 1);
      b2.i_req = 0;
      nxt(); nxt(); nxt(); nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
